// File: rtl/bus_arbiter.sv
`default_nettype none
// bus_arbiter: hands the shared system bus to one of NumReq masters (round-robin or fixed priority)
// and holds it for the whole transaction, with optional lock and a hung-transaction watchdog.
module bus_arbiter #(
  parameter int NumReq        = 2,
  parameter int Mode          = 0,
  parameter int TimeoutCycles = 256
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NumReq-1:0]         req_i,
  input  logic [NumReq-1:0]         lock_i,
  input  logic                      bus_busy_i,
  input  logic                      bus_done_i,
  output logic [NumReq-1:0]         grant_o,
  output logic                      grant_valid_o,
  output logic [$clog2(NumReq)-1:0] grant_id_o,
  output logic                      timeout_o
);

  localparam int IdW  = $clog2(NumReq);
  localparam int CntW = (TimeoutCycles > 1) ? $clog2(TimeoutCycles) : 1;
  localparam logic [CntW-1:0] CntMax = CntW'((TimeoutCycles > 0) ? TimeoutCycles - 1 : 0);

  generate
    if (NumReq < 2 || NumReq > 8) begin : g_bad_numreq
      $error("bus_arbiter: NumReq must be in the range 2..8");
    end
    if (Mode != 0 && Mode != 1) begin : g_bad_mode
      $error("bus_arbiter: Mode must be 0 (round-robin) or 1 (fixed priority)");
    end
    if (TimeoutCycles < 0) begin : g_bad_timeout
      $error("bus_arbiter: TimeoutCycles must not be negative");
    end
  endgenerate

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GRANTED = 2'd1,
    RECOVER = 2'd2
  } state_e;

  state_e            state_q;
  logic [NumReq-1:0] grant_q;
  logic              grant_valid_q;
  logic [IdW-1:0]    grant_id_q;
  logic [IdW-1:0]    last_q;
  logic              timeout_q;
  logic [CntW-1:0]   cnt_q;

  // Returns {found, index}. Round-robin starts the search just after `last`.
  function automatic logic [IdW:0] pick(input logic [NumReq-1:0] mask,
                                        input logic [IdW-1:0]    last);
    logic           found;
    logic [IdW-1:0] idx;
    logic [IdW-1:0] jj;
    int             j;
    found = 1'b0;
    idx   = '0;
    for (int k = 1; k <= NumReq; k++) begin
      j  = (Mode == 1) ? (k - 1) : ((int'(last) + k) % NumReq);
      jj = j[IdW-1:0];
      if (!found && mask[jj]) begin
        found = 1'b1;
        idx   = jj;
      end
    end
    return {found, idx};
  endfunction

  logic [NumReq-1:0] excl_mask;
  logic [NumReq-1:0] others;
  logic [IdW:0]      pick_req;
  logic [IdW:0]      pick_oth;
  logic              hold;
  logic              expire;
  logic              new_found;
  logic [IdW-1:0]    new_id;
  logic              do_take;

  // grant_id_q is kept after a release or timeout so RECOVER knows whom to skip.
  assign excl_mask = NumReq'(1) << grant_id_q;
  assign others    = req_i & ~excl_mask;
  assign pick_req  = pick(req_i, last_q);
  assign pick_oth  = pick(others, last_q);
  assign hold      = req_i[grant_id_q] | lock_i[grant_id_q] | bus_busy_i;
  assign expire    = (TimeoutCycles > 0) && bus_busy_i && !bus_done_i && (cnt_q == CntMax);

  always_comb begin
    new_found = 1'b0;
    new_id    = '0;
    case (state_q)
      IDLE:    {new_found, new_id} = pick_req;
      GRANTED: {new_found, new_id} = pick_oth;
      RECOVER: {new_found, new_id} = pick_oth[IdW] ? pick_oth : pick_req;
      default: {new_found, new_id} = pick_req;
    endcase
  end

  // A releasing holder hands straight over; RECOVER also grants directly so the
  // bus is idle for exactly one cycle after a timeout.
  assign do_take = new_found && ((state_q != GRANTED) || (!expire && !hold));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      grant_q       <= '0;
      grant_valid_q <= 1'b0;
      grant_id_q    <= '0;
      last_q        <= IdW'(NumReq - 1);
      timeout_q     <= 1'b0;
      cnt_q         <= '0;
    end else begin
      timeout_q <= 1'b0;
      if (do_take) begin
        state_q       <= GRANTED;
        grant_q       <= NumReq'(1) << new_id;
        grant_valid_q <= 1'b1;
        grant_id_q    <= new_id;
        last_q        <= new_id;
        cnt_q         <= '0;
      end else begin
        case (state_q)
          GRANTED: begin
            if (expire) begin
              timeout_q     <= 1'b1;
              grant_q       <= '0;
              grant_valid_q <= 1'b0;
              state_q       <= RECOVER;
              cnt_q         <= '0;
            end else if (!hold) begin
              grant_q       <= '0;
              grant_valid_q <= 1'b0;
              state_q       <= IDLE;
              cnt_q         <= '0;
            end else if (bus_busy_i && !bus_done_i) begin
              if (cnt_q != CntMax) cnt_q <= cnt_q + 1'b1;
            end else begin
              cnt_q <= '0;
            end
          end
          default: begin
            state_q       <= IDLE;
            grant_q       <= '0;
            grant_valid_q <= 1'b0;
            cnt_q         <= '0;
          end
        endcase
      end
    end
  end

  assign grant_o       = grant_q;
  assign grant_valid_o = grant_valid_q;
  assign grant_id_o    = grant_id_q;
  assign timeout_o     = timeout_q;

endmodule
`default_nettype wire

// File: tb/tb_bus_arbiter.sv
`default_nettype none
// tb_bus_arbiter: directed scenarios plus randomized traffic against a behavioural model,
// driving a round-robin and a fixed-priority instance from the same inputs.
module tb_bus_arbiter;

  localparam int N = 3;
  localparam int T = 8;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [N-1:0] req, lock;
  logic         busy, done;

  logic [N-1:0] g_rr, g_fp;
  logic         v_rr, v_fp, to_rr, to_fp;
  logic [1:0]   id_rr, id_fp;

  int n_pass  = 0;
  int n_total = 0;

  // Model state, index 0 = round-robin instance, 1 = fixed-priority instance.
  int own[2], lastw[2], run[2], excl[2];
  bit rec[2], tox[2];

  bus_arbiter #(.NumReq(N), .Mode(0), .TimeoutCycles(T)) u_rr (
    .clk(clk), .rst_n(rst_n), .req_i(req), .lock_i(lock), .bus_busy_i(busy), .bus_done_i(done),
    .grant_o(g_rr), .grant_valid_o(v_rr), .grant_id_o(id_rr), .timeout_o(to_rr));

  bus_arbiter #(.NumReq(N), .Mode(1), .TimeoutCycles(T)) u_fp (
    .clk(clk), .rst_n(rst_n), .req_i(req), .lock_i(lock), .bus_busy_i(busy), .bus_done_i(done),
    .grant_o(g_fp), .grant_valid_o(v_fp), .grant_id_o(id_fp), .timeout_o(to_fp));

  always #5 clk = ~clk;

  function automatic int choose(int mode, logic [N-1:0] m, int last);
    if (mode == 1) begin
      for (int j = 0; j < N; j++) if (m[j]) return j;
    end else begin
      for (int j = last + 1; j <= last + N; j++) if (m[j % N]) return j % N;
    end
    return -1;
  endfunction

  task automatic model_reset();
    for (int m = 0; m < 2; m++) begin
      own[m] = -1; lastw[m] = N - 1; run[m] = 0; excl[m] = 0; rec[m] = 0; tox[m] = 0;
    end
  endtask

  task automatic model_step();
    int o, nxt;
    for (int m = 0; m < 2; m++) begin
      tox[m] = 0;
      if (own[m] >= 0) begin
        o = own[m];
        if (busy && !done && run[m] + 1 == T) begin
          tox[m] = 1; excl[m] = o; own[m] = -1; rec[m] = 1; run[m] = 0;
        end else if (busy) begin
          run[m] = done ? 0 : run[m] + 1;
        end else if (!(req[o] || lock[o])) begin
          nxt = choose(m, req & ~(N'(1) << o), lastw[m]);
          own[m] = nxt;
          if (nxt >= 0) lastw[m] = nxt;
          run[m] = 0;
        end else begin
          run[m] = 0;
        end
      end else begin
        if (rec[m]) begin
          nxt = choose(m, req & ~(N'(1) << excl[m]), lastw[m]);
          if (nxt < 0) nxt = choose(m, req, lastw[m]);
          rec[m] = 0;
        end else begin
          nxt = choose(m, req, lastw[m]);
        end
        own[m] = nxt;
        if (nxt >= 0) lastw[m] = nxt;
        run[m] = 0;
      end
    end
  endtask

  function automatic logic [N+3:0] exp_vec(int m);
    logic [N-1:0] g;
    logic [1:0]   id;
    g  = (own[m] >= 0) ? (N'(1) << own[m]) : '0;
    id = (own[m] >= 0) ? 2'(own[m]) : 2'd0;
    return {g, (own[m] >= 0), tox[m], id};
  endfunction

  task automatic cycle();
    @(posedge clk);
    model_step();
    @(negedge clk);
  endtask

  task automatic apply_reset();
    rst_n = 1'b0; req = '0; lock = '0; busy = 1'b0; done = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    n_total++;
    if ({g_rr, v_rr, id_rr, to_rr} !== '0) $display("FAIL reset_rr: got %b expected 0", {g_rr, v_rr, id_rr, to_rr});
    else n_pass++;
    n_total++;
    if ({g_fp, v_fp, id_fp, to_fp} !== '0) $display("FAIL reset_fp: got %b expected 0", {g_fp, v_fp, id_fp, to_fp});
    else n_pass++;
    rst_n = 1'b1;
    cycle();
    n_total++;
    if ({g_rr, v_rr, to_rr} !== '0) $display("FAIL idle_after_reset: got %b expected 0", {g_rr, v_rr, to_rr});
    else n_pass++;
  endtask

  task automatic test_single();
    apply_reset();
    req = 3'b001;
    cycle();
    n_total++;
    if ({g_rr, v_rr, id_rr} !== {3'b001, 1'b1, 2'd0}) $display("FAIL single_grant_rr: got %b expected 001_1_00", {g_rr, v_rr, id_rr});
    else n_pass++;
    n_total++;
    if ({g_fp, v_fp, id_fp} !== {3'b001, 1'b1, 2'd0}) $display("FAIL single_grant_fp: got %b expected 001_1_00", {g_fp, v_fp, id_fp});
    else n_pass++;
    req = '0;
    cycle();
    n_total++;
    if ({g_rr, v_rr} !== '0) $display("FAIL single_release: got %b expected 0", {g_rr, v_rr});
    else n_pass++;
  endtask

  task automatic test_round_robin();
    int h;
    apply_reset();
    req = 3'b011;
    cycle();
    h = 0;
    n_total++;
    if (g_rr !== 3'b001) $display("FAIL rr_first: got %b expected 001", g_rr);
    else n_pass++;
    for (int i = 0; i < 4; i++) begin
      busy = 1'b1;
      cycle();
      done = 1'b1;
      cycle();
      done = 1'b0; busy = 1'b0; req[h] = 1'b0;
      cycle();
      h = 1 - h;
      n_total++;
      if ({g_rr, v_rr} !== {N'(1) << h, 1'b1}) $display("FAIL rr_alternate[%0d]: got %b expected %b", i, {g_rr, v_rr}, {N'(1) << h, 1'b1});
      else n_pass++;
      req = 3'b011;
    end
  endtask

  task automatic test_fixed_priority();
    apply_reset();
    req = 3'b011;
    cycle();
    n_total++;
    if (g_fp !== 3'b001) $display("FAIL fp_first: got %b expected 001", g_fp);
    else n_pass++;
    cycle(); cycle();
    n_total++;
    if (g_fp !== 3'b001) $display("FAIL fp_wait: got %b expected 001", g_fp);
    else n_pass++;
    req = 3'b010;
    cycle();
    n_total++;
    if (g_fp !== 3'b010) $display("FAIL fp_handover: got %b expected 010", g_fp);
    else n_pass++;
    req = 3'b011;
    cycle(); cycle();
    n_total++;
    if (g_fp !== 3'b010) $display("FAIL fp_no_preempt: got %b expected 010", g_fp);
    else n_pass++;
    req = 3'b001;
    cycle();
    n_total++;
    if (g_fp !== 3'b001) $display("FAIL fp_back: got %b expected 001", g_fp);
    else n_pass++;
  endtask

  task automatic test_busy_lock();
    apply_reset();
    req = 3'b001;
    cycle();
    busy = 1'b1; req = '0;
    cycle(); cycle();
    n_total++;
    if ({g_rr, g_fp} !== {3'b001, 3'b001}) $display("FAIL busy_hold: got %b expected 001001", {g_rr, g_fp});
    else n_pass++;
    busy = 1'b0;
    cycle();
    n_total++;
    if ({g_rr, v_rr} !== '0) $display("FAIL busy_release: got %b expected 0", {g_rr, v_rr});
    else n_pass++;
    req = 3'b010;
    cycle();
    req = '0; lock = 3'b010;
    repeat (3) cycle();
    n_total++;
    if (g_rr !== 3'b010) $display("FAIL lock_hold: got %b expected 010", g_rr);
    else n_pass++;
    lock = '0;
    cycle();
    n_total++;
    if (g_rr !== 3'b000) $display("FAIL lock_release: got %b expected 000", g_rr);
    else n_pass++;
  endtask

  task automatic test_watchdog();
    apply_reset();
    req = 3'b011;
    cycle();
    busy = 1'b1;
    for (int k = 1; k <= 7; k++) begin
      cycle();
      n_total++;
      if ({to_rr, g_rr} !== {1'b0, 3'b001}) $display("FAIL wd_early[%0d]: got %b expected 0001", k, {to_rr, g_rr});
      else n_pass++;
    end
    cycle();
    n_total++;
    if ({to_rr, g_rr, v_rr, to_fp} !== {1'b1, 3'b000, 1'b0, 1'b1}) $display("FAIL wd_fire: got %b expected 100001", {to_rr, g_rr, v_rr, to_fp});
    else n_pass++;
    busy = 1'b0;
    cycle();
    n_total++;
    if ({to_rr, g_rr} !== {1'b0, 3'b010}) $display("FAIL wd_recover_rr: got %b expected 0010", {to_rr, g_rr});
    else n_pass++;
    n_total++;
    if ({to_fp, g_fp} !== {1'b0, 3'b010}) $display("FAIL wd_exclude_fp: got %b expected 0010", {to_fp, g_fp});
    else n_pass++;

    apply_reset();
    req = 3'b001;
    cycle();
    busy = 1'b1;
    repeat (6) cycle();
    done = 1'b1;
    cycle();
    done = 1'b0;
    for (int k = 8; k <= 11; k++) begin
      cycle();
      n_total++;
      if ({to_rr, g_rr} !== {1'b0, 3'b001}) $display("FAIL wd_done_clears[%0d]: got %b expected 0001", k, {to_rr, g_rr});
      else n_pass++;
    end
    busy = 1'b0; req = '0;
    cycle();
  endtask

  task automatic test_async_reset();
    apply_reset();
    req = 3'b001;
    cycle();
    busy = 1'b1;
    cycle();
    #2 rst_n = 1'b0;
    #1;
    n_total++;
    if ({g_rr, v_rr, to_rr, g_fp, v_fp, to_fp} !== '0) $display("FAIL async_reset: got %b expected 0", {g_rr, v_rr, to_rr, g_fp, v_fp, to_fp});
    else n_pass++;
    model_reset();
    @(negedge clk);
    busy = 1'b0; req = 3'b011; rst_n = 1'b1;
    cycle();
    n_total++;
    if ({g_rr, g_fp} !== {3'b001, 3'b001}) $display("FAIL after_reset_order: got %b expected 001001", {g_rr, g_fp});
    else n_pass++;
  endtask

  task automatic test_random();
    apply_reset();
    for (int i = 0; i < 600; i++) begin
      req  = N'($urandom_range(0, (1 << N) - 1));
      lock = ($urandom_range(0, 7) == 0) ? N'($urandom_range(0, (1 << N) - 1)) : '0;
      busy = busy ? ($urandom_range(0, 19) != 0) : ($urandom_range(0, 2) == 0);
      done = busy && ($urandom_range(0, 9) == 0);
      cycle();
      n_total++;
      if ({g_rr, v_rr, to_rr, (v_rr ? id_rr : 2'd0)} !== exp_vec(0))
        $display("FAIL rand_rr[%0d]: got %b expected %b", i, {g_rr, v_rr, to_rr, (v_rr ? id_rr : 2'd0)}, exp_vec(0));
      else n_pass++;
      n_total++;
      if ({g_fp, v_fp, to_fp, (v_fp ? id_fp : 2'd0)} !== exp_vec(1))
        $display("FAIL rand_fp[%0d]: got %b expected %b", i, {g_fp, v_fp, to_fp, (v_fp ? id_fp : 2'd0)}, exp_vec(1));
      else n_pass++;
      n_total++;
      if (!$onehot0(g_rr) || v_rr !== |g_rr || !$onehot0(g_fp) || v_fp !== |g_fp)
        $display("FAIL rand_invariant[%0d]: got %b expected onehot0 grants with matching valid", i, {g_rr, v_rr, g_fp, v_fp});
      else n_pass++;
    end
    busy = 1'b0; done = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; req = '0; lock = '0; busy = 1'b0; done = 1'b0;
    model_reset();
    test_reset();
    test_single();
    test_round_robin();
    test_fixed_priority();
    test_busy_lock();
    test_watchdog();
    test_async_reset();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL sim_time_limit: got no finish expected finish before 1000000");
    $fatal(1, "time limit");
  end

endmodule
`default_nettype wire

// File: doc/bus_arbiter.md
Name: bus_arbiter

Overview:
- Arbitrates ownership of the shared arilla system bus between multiple bus masters: the rv_core hart, the debug module's system-bus access path, and future DMA.
- Sits between the masters and the bus address/data mux.
- Produces a one-hot grant and a winner index that drive the mux.
- Grants last from request to transaction completion, with optional multi-transaction locking and a hung-transaction watchdog.

Parameters:
- NumReq, 2, number of requesting masters (2..8); index 0 = rv_core, 1 = dm.
- Mode, 0, 0 = round-robin, 1 = fixed priority (lowest index wins).
- TimeoutCycles, 256, maximum consecutive bus_busy cycles before a forced release; 0 disables the watchdog.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  reset; asynchronous assert, active-low.
- req  in  NumReq  per-master request level; held high until the master no longer needs the bus.
- lock  in  NumReq  per-master lock; while it is high, the holder keeps the grant even with req low.
- bus_busy  in  1  a transaction is in flight on the bus (from the slaves' response logic).
- bus_done  in  1  single-cycle completion pulse for the current transaction.
- grant  out  NumReq  one-hot grant, registered.
- grant_valid  out  1  OR of grant, registered.
- grant_id  out  $clog2(NumReq)  index of the holder, registered; valid only while grant_valid is high.
- timeout  out  1  single-cycle pulse when the watchdog fires.

Behaviour:
- Interface:
  - One clock (clk).
  - Reset is asynchronous and active-low (rst_n).
  - All outputs are registered.
- Reset values:
  - grant=0, grant_valid=0, grant_id=0, timeout=0.
  - State IDLE, watchdog counter=0.
  - Round-robin last_winner=NumReq-1, so master 0 wins first.
- States: IDLE, GRANTED, RECOVER.
- IDLE:
  - If any req bit is high, the winner is registered, with grant visible the next edge. Latency is req→grant = 1 cycle.
  - Otherwise stay in IDLE.
- Winner selection:
  - Mode 0: first set req bit, searching from last_winner+1 upward with wrap-around at NumReq-1→0.
  - Mode 1: lowest set index.
  - last_winner updates on every new grant.
- GRANTED, hold condition: req[id] | lock[id] | bus_busy.
- GRANTED, release (hold condition false):
  - Re-arbitrate in the same cycle over the req bits of all other masters (the releasing master is excluded for that cycle).
  - If another master is requesting, the grant moves to it on the next edge with no idle cycle.
  - Otherwise clear the grant and go to IDLE.
- Grant stability:
  - grant never changes while bus_busy is high, except on watchdog expiry.
  - A holder that drops req mid-transaction keeps the grant until bus_busy falls.
- Watchdog (TimeoutCycles>0):
  - The counter increments each GRANTED cycle with bus_busy high.
  - It clears on bus_done, on !bus_busy, and on any grant change.
  - When the counter reaches TimeoutCycles-1 while still busy:
    - next edge: timeout=1 for one cycle, grant=0, state RECOVER.
    - The counter saturates; it never wraps.
- RECOVER:
  - Lasts exactly one cycle with grant=0, then goes to IDLE.
  - The timed-out master is excluded from the next arbitration only if another master is requesting.
- Simultaneous events:
  - bus_done in the same cycle as expiry: bus_done wins, no timeout.
  - req deasserted in the same cycle as being granted: the grant is still issued for one cycle, then released normally.
- Invariants:
  - $onehot0(grant) always holds.
  - grant_valid == |grant.
  - grant_id matches the grant bit.
- Reset mid-operation: all state clears asynchronously; the first grant after reset follows reset ordering.
- Parameters outside NumReq 2..8 are a $error at elaboration.

Test Plan:
- Single request: reset, then req=01 → grant=01 one cycle later, grant_id=0; drop req with bus_busy=0 → grant=00 next cycle, state IDLE.
- Round-robin contention: Mode 0, req=11 held, each grantee completes a bus_done transaction then drops and re-raises req → grants alternate 01,10,01,10 with no idle cycle between them.
- Fixed priority: Mode 1, req=11 → master 0 granted; master 1 waits until master 0 releases; master 0 re-requests while 1 holds → 1 keeps the grant until its release.
- Busy/lock hold:
  - Holder drops req while bus_busy=1 → grant held until bus_busy=0.
  - lock=1 with req=0 and bus_busy=0 → grant held until lock falls.
- Watchdog:
  - TimeoutCycles=8, holder keeps bus_busy=1 with no bus_done → on cycle 8, timeout pulses once, grant=0 for one cycle, then the other requester is granted.
  - bus_done on cycle 7 → no timeout.
- Async reset: assert rst_n=0 mid-grant with bus_busy=1 → grant, grant_valid and timeout go to 0 immediately without waiting for a clock edge; after release, req=11 in Mode 0 → master 0 wins.
